// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receive-side signal bundle: raw pins in, decoded scan-code stream out.
interface ps2_scancode_rx_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] ps2_code;
    logic       ps2_code_new;
    logic       frame_error;
    logic       rx_busy;

    // master: the frame decoder; slave: pin driver and scan-code consumer
    modport master (
        input  ps2_clock,
        input  ps2_data,
        output ps2_code,
        output ps2_code_new,
        output frame_error,
        output rx_busy
    );

    modport slave (
        output ps2_clock,
        output ps2_data,
        input  ps2_code,
        input  ps2_code_new,
        input  frame_error,
        input  rx_busy
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// Receive-only PS/2 device-to-host frame decoder: synchronise, deglitch clock,
// deserialise start/8 data/odd parity/stop, emit raw bytes with a one-cycle strobe.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input logic              clock,
    input logic              reset_n,
    ps2_scancode_rx_if.master ps2
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic              clk_s1, clk_s2;
    logic              dat_s1, dat_s2;
    logic              clk_f, clk_f_d;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall_c;

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        code_q, code_d;
    logic              new_q, new_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    // Two-stage synchronisers; idle-high reset matches the bus idle level
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2.ps2_clock;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock filter: follow a new level only after it has held for FILTER_LEN clocks
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_f    <= 1'b1;
            clk_f_d  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                clk_f    <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    assign fall_c = clk_f_d & ~clk_f;

    // FSM and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            code_q  <= 8'h00;
            new_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            new_q   <= new_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output decode; a sampled fall always wins over timeout
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        code_d  = code_q;
        new_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = (state_q == IDLE || fall_c) ? '0 : tmo_q + TMO_W'(1);

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    if (!dat_s2) begin
                        shift_d = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_d = {dat_s2, shift_q[7:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(7)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_c) begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    if (dat_s2 && ((^shift_q) ^ par_q)) begin
                        code_d = shift_q;
                        new_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!fall_c && state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    assign ps2.ps2_code     = code_q;
    assign ps2.ps2_code_new = new_q;
    assign ps2.frame_error  = err_q;
    assign ps2.rx_busy      = busy_q;

endmodule
